axi_ad9963_up_master: RTL and testbench
=======================================

// Module: axi_ad9963_up_master
// PURPOSE
//  AXI4-Lite slave to up_* register-bus initiator; drives the up_wreq/up_rreq side of the
//  AD9963 core register bus (tx/rx channels, up_dac_common, up_adc_common responders).
//  Serialises AXI reads/writes into single up_ transactions with a bounded ack timeout.
//  One transaction outstanding at a time; single clock domain.
// PARAMETERS
//  TIMEOUT_CYCLES  64            max cycles to wait for up_wack/up_rack; legal 2..65535
//  ERR_DATA        32'hDEAD_DEAD rdata returned on read timeout
// PORTS
//  up_clk         in   1   clock (all logic)
//  up_rstn        in   1   reset, asynchronous, active-low
//  s_axi_awvalid  in   1   / s_axi_awready out 1 : write address handshake
//  s_axi_awaddr   in   16  byte address; up_waddr = awaddr[15:2]
//  s_axi_wvalid   in   1   / s_axi_wready  out 1 : write data handshake
//  s_axi_wdata    in   32  write data
//  s_axi_wstrb    in   4   ignored; up bus is full-word only
//  s_axi_bvalid   out  1   / s_axi_bready  in  1 : write response
//  s_axi_bresp    out  2   00 OKAY, 10 SLVERR (timeout)
//  s_axi_arvalid  in   1   / s_axi_arready out 1 : read address handshake
//  s_axi_araddr   in   16  byte address; up_raddr = araddr[15:2]
//  s_axi_rvalid   out  1   / s_axi_rready  in  1 : read response
//  s_axi_rresp    out  2   00 OKAY, 10 SLVERR
//  s_axi_rdata    out  32  read data
//  up_wreq out 1 | up_waddr out 14 | up_wdata out 32 | up_wack in 1   : up write channel
//  up_rreq out 1 | up_raddr out 14 | up_rdata in 32  | up_rack in 1   : up read channel
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output (state IDLE, counter 0).
//  - FSM: IDLE -> WREQ -> WWAIT -> WRESP -> IDLE ; IDLE -> RREQ -> RWAIT -> RRESP -> IDLE.
//  - IDLE: write eligible when awvalid&wvalid both high; read eligible when arvalid high.
//    Both eligible: alternate, serve opposite of last-served type; after reset write first.
//  - Cycle N in IDLE selects; cycle N+1 (xREQ): awready=wready=1 (or arready=1) and
//    up_wreq (or up_rreq)=1 for exactly one cycle, addr/data latched from cycle N.
//  - Addr/data outputs hold their latched value until the next request; wreq/rreq never both 1.
//  - xWAIT: counter from 1; ack sampled only in xWAIT (ack coincident with req ignored).
//    Ack seen at cycle req+k, 1<=k<=TIMEOUT_CYCLES -> bvalid/rvalid=1 at req+k+1, resp 00,
//    rdata = up_rdata sampled on the up_rack cycle.
//  - No ack by req+TIMEOUT_CYCLES -> response at req+TIMEOUT_CYCLES+1, resp 10,
//    rdata = ERR_DATA.
//  - xRESP: bvalid/rvalid held with stable resp/data until bready/rready; handshake cycle
//    drops valid next cycle and returns to IDLE; next request earliest 1 cycle later.
//  - Acks outside xWAIT (late after timeout, spurious, wrong channel) ignored, no effect.
//  - up_wack during RWAIT / up_rack during WWAIT ignored.
//  - up_rstn low at any time: immediate return to IDLE, all outputs 0, in-flight
//    transaction discarded, no AXI response issued.
// TESTING
//  - Write 0x0044<-0x12345678, up_wack at req+2 -> up_waddr=0x011, up_wdata=0x12345678,
//    up_wreq 1 cycle, bvalid at req+3, bresp=00.
//  - Read 0x0048, up_rack at req+1 with up_rdata=0xA5A5_0001 -> up_raddr=0x012,
//    rvalid at req+2, rdata=0xA5A5_0001, rresp=00.
//  - Write, no ack ever -> bvalid at req+65 (default), bresp=10;
//    read, no ack -> rdata=0xDEAD_DEAD, rresp=10; late ack next cycle ignored.
//  - aw/w/ar all valid, persistently -> order W,R,W,R; never wreq and rreq in same cycle.
//  - rready low 10 cycles after rvalid -> rvalid/rdata stable 10 cycles, no new up_rreq.
//  - up_rstn low during WWAIT -> all outputs 0 next edge; later ack produces no bvalid.

Source files
------------

// File: rtl/axi_ad9963_up_master_if.sv
// Bus bundles for the AXI4-Lite to up_* bridge.
// axi_lite_if: AXI4-Lite channels; up_bus_if: up_ register bus.
interface axi_lite_if;
  logic        awvalid;
  logic        awready;
  logic [15:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [15:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rresp, rdata
  );

  modport slave (
    input  awvalid, awaddr,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rresp, rdata
  );
endinterface

interface up_bus_if;
  logic        wreq;
  logic [13:0] waddr;
  logic [31:0] wdata;
  logic        wack;
  logic        rreq;
  logic [13:0] raddr;
  logic [31:0] rdata;
  logic        rack;

  modport master (
    output wreq, waddr, wdata,
    output rreq, raddr,
    input  wack, rdata, rack
  );

  modport slave (
    input  wreq, waddr, wdata,
    input  rreq, raddr,
    output wack, rdata, rack
  );
endinterface

// File: rtl/axi_ad9963_up_master.sv
// AXI4-Lite slave serialising reads/writes onto the up_* bus.
// Ports: up_clk, up_rstn (async low), s_axi (slave), up (master).
module axi_ad9963_up_master #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_DEAD
) (
  input  logic       up_clk,
  input  logic       up_rstn,
  axi_lite_if.slave  s_axi,
  up_bus_if.master   up
);

  typedef enum logic [2:0] {
    IDLE,
    WREQ,
    WWAIT,
    WRESP,
    RREQ,
    RWAIT,
    RRESP
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] cnt;
  logic        last_rd;
  logic        wr_ok;
  logic        rd_ok;
  logic        pick_wr;
  logic        unused_bits;

  assign wr_ok = s_axi.awvalid & s_axi.wvalid;
  assign rd_ok = s_axi.arvalid;
  // On contention serve the type not served last.
  assign pick_wr = wr_ok & (~rd_ok | last_rd);

  assign unused_bits = ^{s_axi.wstrb,
                         s_axi.awaddr[1:0],
                         s_axi.araddr[1:0]};

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      last_rd       <= 1'b1;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= 2'b00;
      s_axi.rdata   <= '0;
      up.wreq       <= 1'b0;
      up.waddr      <= '0;
      up.wdata      <= '0;
      up.rreq       <= 1'b0;
      up.raddr      <= '0;
    end else begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.arready <= 1'b0;
      up.wreq       <= 1'b0;
      up.rreq       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_wr) begin
            state         <= WREQ;
            last_rd       <= 1'b0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            up.wreq       <= 1'b1;
            up.waddr      <= s_axi.awaddr[15:2];
            up.wdata      <= s_axi.wdata;
          end else if (rd_ok) begin
            state         <= RREQ;
            last_rd       <= 1'b1;
            s_axi.arready <= 1'b1;
            up.rreq       <= 1'b1;
            up.raddr      <= s_axi.araddr[15:2];
          end
        end
        WREQ: begin
          state <= WWAIT;
          cnt   <= 16'd1;
        end
        WWAIT: begin
          if (up.wack) begin
            state        <= WRESP;
            cnt          <= '0;
            s_axi.bvalid <= 1'b1;
            s_axi.bresp  <= 2'b00;
          end else if (cnt == TMO) begin
            state        <= WRESP;
            cnt          <= '0;
            s_axi.bvalid <= 1'b1;
            s_axi.bresp  <= 2'b10;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WRESP: begin
          if (s_axi.bready) begin
            state        <= IDLE;
            s_axi.bvalid <= 1'b0;
            s_axi.bresp  <= 2'b00;
          end
        end
        RREQ: begin
          state <= RWAIT;
          cnt   <= 16'd1;
        end
        RWAIT: begin
          if (up.rack) begin
            state        <= RRESP;
            cnt          <= '0;
            s_axi.rvalid <= 1'b1;
            s_axi.rresp  <= 2'b00;
            s_axi.rdata  <= up.rdata;
          end else if (cnt == TMO) begin
            state        <= RRESP;
            cnt          <= '0;
            s_axi.rvalid <= 1'b1;
            s_axi.rresp  <= 2'b10;
            s_axi.rdata  <= ERR_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RRESP: begin
          if (s_axi.rready) begin
            state        <= IDLE;
            s_axi.rvalid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ad9963_up_master.sv
// Randomised self-checking bench for axi_ad9963_up_master.
// Acts as AXI master and up_ responder; checks timing against rules.
module tb_axi_ad9963_up_master;

  localparam int          T   = 64;
  localparam logic [31:0] ERR = 32'hDEAD_DEAD;

  logic up_clk = 1'b0;
  logic up_rstn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  axi_lite_if axi();
  up_bus_if   up();

  axi_ad9963_up_master #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA(ERR)
  ) dut (
    .up_clk(up_clk),
    .up_rstn(up_rstn),
    .s_axi(axi),
    .up(up)
  );

  always #5 up_clk = ~up_clk;

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ack at req+k is honoured when 1<=k<=T; response one cycle later.
  function automatic int exp_lat(input int k);
    return (k >= 1 && k <= T) ? k + 1 : T + 1;
  endfunction

  function automatic logic [31:0] exp_resp(input int k);
    return (k >= 1 && k <= T) ? 32'd0 : 32'd2;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus"}, 32'({axi.awready, axi.wready,
                            axi.arready, axi.bvalid,
                            axi.rvalid, up.wreq,
                            up.rreq}), 0);
    chk({tag, "_resp"}, 32'({axi.bresp, axi.rresp}), 0);
    chk({tag, "_rdata"}, axi.rdata, 0);
    chk({tag, "_wdata"}, up.wdata, 0);
    chk({tag, "_addr"}, 32'({up.waddr, up.raddr}), 0);
  endtask

  task automatic do_write(input logic [15:0] addr,
                          input logic [31:0] data,
                          input int k,
                          input int hold);
    int   lat;
    int   extra;
    logic found;
    logic stable;
    logic [1:0] br;
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = 4'($urandom);
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (up.wreq) found = 1'b1;
    end
    chk("wreq_seen", 32'(found), 1);
    chk("aw_w_ready", 32'({axi.awready, axi.wready}), 3);
    chk("waddr", 32'(up.waddr), 32'(addr[15:2]));
    chk("wdata", up.wdata, data);
    chk("rreq_in_wr", 32'(up.rreq), 0);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.awaddr  = 16'($urandom);
    axi.wdata   = $urandom;
    up.wack     = 1'($urandom);
    lat   = 0;
    extra = 0;
    for (int i = 1; i <= T + 5 && lat == 0; i++) begin
      tick();
      if (up.wreq) extra++;
      if (axi.bvalid) begin
        lat = i;
      end else begin
        up.wack = (i == k);
        up.rack = 1'($urandom);
      end
    end
    up.wack = 1'b0;
    up.rack = 1'b0;
    chk("b_latency", 32'(lat), 32'(exp_lat(k)));
    chk("bresp", 32'(axi.bresp), exp_resp(k));
    chk("waddr_hold", 32'(up.waddr), 32'(addr[15:2]));
    chk("wdata_hold", up.wdata, data);
    br = axi.bresp;
    stable = 1'b1;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      up.wack = 1'($urandom);
      tick();
      if (!axi.bvalid || axi.bresp !== br) stable = 1'b0;
      if (up.wreq) extra++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    up.wack     = 1'b0;
    axi.bready  = 1'b1;
    tick();
    chk("bvalid_drop", 32'(axi.bvalid), 0);
    axi.bready = 1'b0;
    chk("b_stable", 32'(stable), 1);
    chk("wreq_extra", 32'(extra), 0);
  endtask

  task automatic do_read(input logic [15:0] addr,
                         input logic [31:0] val,
                         input int k,
                         input int hold);
    int   lat;
    int   extra;
    logic found;
    logic stable;
    logic [31:0] rd;
    logic [1:0]  rr;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (up.rreq) found = 1'b1;
    end
    chk("rreq_seen", 32'(found), 1);
    chk("arready", 32'(axi.arready), 1);
    chk("raddr", 32'(up.raddr), 32'(addr[15:2]));
    chk("wreq_in_rd", 32'(up.wreq), 0);
    axi.arvalid = 1'b0;
    axi.araddr  = 16'($urandom);
    up.rack     = 1'($urandom);
    up.rdata    = $urandom;
    lat   = 0;
    extra = 0;
    for (int i = 1; i <= T + 5 && lat == 0; i++) begin
      tick();
      if (up.rreq) extra++;
      if (axi.rvalid) begin
        lat = i;
      end else begin
        up.rack  = (i == k);
        up.rdata = (i == k) ? val : $urandom;
        up.wack  = 1'($urandom);
      end
    end
    up.rack = 1'b0;
    up.wack = 1'b0;
    chk("r_latency", 32'(lat), 32'(exp_lat(k)));
    chk("rresp", 32'(axi.rresp), exp_resp(k));
    chk("rdata", axi.rdata,
        (k >= 1 && k <= T) ? val : ERR);
    chk("raddr_hold", 32'(up.raddr), 32'(addr[15:2]));
    rd = axi.rdata;
    rr = axi.rresp;
    stable = 1'b1;
    axi.arvalid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      up.rdata = $urandom;
      up.rack  = 1'($urandom);
      tick();
      if (!axi.rvalid || axi.rdata !== rd) stable = 1'b0;
      if (axi.rresp !== rr) stable = 1'b0;
      if (up.rreq) extra++;
    end
    axi.arvalid = 1'b0;
    up.rack     = 1'b0;
    axi.rready  = 1'b1;
    tick();
    chk("rvalid_drop", 32'(axi.rvalid), 0);
    axi.rready = 1'b0;
    chk("r_stable", 32'(stable), 1);
    chk("rreq_extra", 32'(extra), 0);
  endtask

  initial begin
    int   kinds[$];
    int   both;
    int   k;
    logic pw;
    logic pr;
    logic cw;
    logic cr;
    logic seen;

    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.rready  = 1'b0;
    up.wack     = 1'b0;
    up.rack     = 1'b0;
    up.rdata    = '0;

    tick();
    tick();
    chk_idle_outputs("reset");
    up_rstn = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Contention: all valids held, quick acks.
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.arvalid = 1'b1;
    axi.awaddr  = 16'($urandom);
    axi.araddr  = 16'($urandom);
    axi.bready  = 1'b1;
    axi.rready  = 1'b1;
    pw   = 1'b0;
    pr   = 1'b0;
    both = 0;
    for (int c = 0; c < 48; c++) begin
      if (c == 40) begin
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.arvalid = 1'b0;
      end
      tick();
      cw = up.wreq;
      cr = up.rreq;
      if (cw && cr) both++;
      if (cw) kinds.push_back(0);
      if (cr) kinds.push_back(1);
      up.wack = pw;
      up.rack = pr;
      pw = cw;
      pr = cr;
    end
    up.wack    = 1'b0;
    up.rack    = 1'b0;
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    tick();
    chk("both_req", 32'(both), 0);
    chk("n_req_ge6", 32'(kinds.size() >= 6), 1);
    for (int i = 0; i < 6 && i < kinds.size(); i++)
      chk("alt_order", 32'(kinds[i]), 32'(i % 2));

    // Directed cases.
    do_write(16'h0044, 32'h1234_5678, 2, 0);
    do_read(16'h0048, 32'hA5A5_0001, 1, 0);
    do_write(16'h0100, 32'hCAFE_0001, 0, 1);
    do_read(16'h0104, 32'h1111_2222, 0, 0);
    up.rack = 1'b1;
    tick();
    up.rack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (axi.rvalid || up.rreq) seen = 1'b1;
    end
    chk("late_rack", 32'(seen), 0);
    do_read(16'h0200, 32'h0BAD_F00D, 3, 10);
    do_write(16'hFFFC, 32'hFFFF_FFFF, T, 2);
    do_read(16'h0004, 32'h5555_AAAA, T, 0);

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 9);
      if (k == 9) k = $urandom_range(T - 1, T + 2);
      if ($urandom_range(0, 1) == 1)
        do_write(16'($urandom), $urandom, k,
                 $urandom_range(0, 3));
      else
        do_read(16'($urandom), $urandom, k,
                $urandom_range(0, 3));
    end

    // Reset while a write waits for its ack.
    axi.awaddr  = 16'h0044;
    axi.wdata   = 32'h7777_8888;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (up.wreq) seen = 1'b1;
    end
    chk("rst_wreq_seen", 32'(seen), 1);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    tick();
    tick();
    #2;
    up_rstn = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    tick();
    chk_idle_outputs("rst_edge");
    up_rstn = 1'b1;
    axi.bready = 1'b1;
    up.wack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < T + 8; i++) begin
      if (i == 3) up.wack = 1'b0;
      tick();
      if (axi.bvalid || up.wreq) seen = 1'b1;
    end
    axi.bready = 1'b0;
    chk("no_b_after_rst", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
